// File: rtl/vga_sync_decoder_if.sv
// Sync input pair and recovered timing outputs of the VGA sync decoder.
// The master drives hsync/vsync; the decoder sits on the slave side.
interface vga_sync_decoder_if;
    logic       hsync;
    logic       vsync;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_active;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       h_err;
    logic       v_err;

    modport master (
        output hsync,
        output vsync,
        input  x,
        input  y,
        input  video_active,
        input  line_start,
        input  frame_start,
        input  locked,
        input  h_err,
        input  v_err
    );

    modport slave (
        input  hsync,
        input  vsync,
        output x,
        output y,
        output video_active,
        output line_start,
        output frame_start,
        output locked,
        output h_err,
        output v_err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers coordinates, checks line/frame
// timing and gates video_active behind a lock state machine.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int V_FP        = 10,
    parameter int LOCK_FRAMES = 2
) (
    input logic clk,
    input logic rst,
    vga_sync_decoder_if.slave bus
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_HI   = 10'(H_TOTAL - H_FP);
    localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_HI   = 10'(V_TOTAL - V_FP);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_WID  = 10'(H_SYNC);
    localparam logic [9:0] V_WID  = 10'(V_SYNC);
    localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);
    localparam logic [9:0] SAT    = 10'h3FF;

    function automatic logic [9:0] sat_inc(
        input logic [9:0] v
    );
        return (v == SAT) ? v : v + 10'd1;
    endfunction

    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [9:0] hhi_q, hhi_d;
    logic [9:0] vhi_q, vhi_d;
    logic       h_seen_q, h_seen_d;
    logic       v_seen_q, v_seen_d;
    logic [1:0] state_q, state_d;
    logic [2:0] good_q, good_d;

    logic       ls1_q, fs1_q, he1_q, ve1_q;

    logic [9:0] x_q, y_q;
    logic       va_q, ls_q, fs_q;
    logic       lk_q, he_q, ve_q;

    logic hs_rise, hs_fall, fr_edge;
    logic timeout;
    logic h_per_err, h_wid_err;
    logic v_per_err, v_wid_err;
    logic h_err_d, v_err_d, any_err;
    logic in_h, in_v;

    assign hs_rise = bus.hsync & ~hs_prev_q;
    assign hs_fall = ~bus.hsync & hs_prev_q;
    assign fr_edge = hs_rise & bus.vsync & ~vs_prev_q;

    // Fires once on the transition into saturation, never while parked.
    assign timeout = ~hs_rise & (hpos_q == SAT - 10'd1);

    assign h_per_err = hs_rise & h_seen_q
                     & (hpos_q != H_LAST);
    assign h_wid_err = hs_fall & h_seen_q
                     & (hhi_q != H_WID);
    assign v_per_err = fr_edge & v_seen_q
                     & (vpos_q != V_LAST);
    assign v_wid_err = hs_rise & ~bus.vsync
                     & vs_prev_q & v_seen_q
                     & (vhi_q != V_WID);

    assign h_err_d = h_per_err | h_wid_err | timeout;
    assign v_err_d = v_per_err | v_wid_err;
    assign any_err = h_err_d | v_err_d;

    always_comb begin
        hs_prev_d = bus.hsync;
        hpos_d    = hs_rise ? 10'd0 : sat_inc(hpos_q);

        hhi_d = hhi_q;
        if (hs_rise) begin
            hhi_d = 10'd1;
        end else if (bus.hsync) begin
            hhi_d = sat_inc(hhi_q);
        end

        h_seen_d = h_seen_q;
        if (timeout) begin
            h_seen_d = 1'b0;
        end else if (hs_rise) begin
            h_seen_d = 1'b1;
        end

        vs_prev_d = vs_prev_q;
        vpos_d    = vpos_q;
        vhi_d     = vhi_q;
        if (hs_rise) begin
            vs_prev_d = bus.vsync;
            vpos_d    = fr_edge ? 10'd0
                                : sat_inc(vpos_q);
            if (bus.vsync) begin
                vhi_d = fr_edge ? 10'd1
                                : sat_inc(vhi_q);
            end
        end

        v_seen_d = v_seen_q;
        if (timeout) begin
            v_seen_d = 1'b0;
        end else if (fr_edge) begin
            v_seen_d = 1'b1;
        end
    end

    // Any error on an edge outranks a lock or verify transition.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            S_SEARCH: begin
                if (fr_edge && !any_err) begin
                    state_d = S_VERIFY;
                    good_d  = 3'd0;
                end
            end
            S_VERIFY: begin
                if (any_err) begin
                    state_d = S_SEARCH;
                end else if (fr_edge) begin
                    good_d = good_q + 3'd1;
                    if (good_q + 3'd1 == LOCK_N) begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (any_err) begin
                    state_d = S_SEARCH;
                end
            end
            default: begin
                state_d = S_SEARCH;
            end
        endcase
    end

    assign in_h = (hpos_q >= H_LO) && (hpos_q < H_HI);
    assign in_v = (vpos_q >= V_LO) && (vpos_q < V_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            hpos_q    <= 10'd0;
            vpos_q    <= 10'd0;
            hhi_q     <= 10'd0;
            vhi_q     <= 10'd0;
            h_seen_q  <= 1'b0;
            v_seen_q  <= 1'b0;
            state_q   <= S_SEARCH;
            good_q    <= 3'd0;
            ls1_q     <= 1'b0;
            fs1_q     <= 1'b0;
            he1_q     <= 1'b0;
            ve1_q     <= 1'b0;
        end else begin
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            hhi_q     <= hhi_d;
            vhi_q     <= vhi_d;
            h_seen_q  <= h_seen_d;
            v_seen_q  <= v_seen_d;
            state_q   <= state_d;
            good_q    <= good_d;
            ls1_q     <= hs_rise;
            fs1_q     <= fr_edge;
            he1_q     <= h_err_d;
            ve1_q     <= v_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= 10'd0;
            y_q  <= 10'd0;
            va_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            lk_q <= 1'b0;
            he_q <= 1'b0;
            ve_q <= 1'b0;
        end else begin
            x_q  <= hpos_q - H_LO;
            y_q  <= vpos_q - V_LO;
            va_q <= (state_q == S_LOCKED)
                    && in_h && in_v;
            ls_q <= ls1_q;
            fs_q <= fs1_q;
            lk_q <= (state_q == S_LOCKED);
            he_q <= he1_q;
            ve_q <= ve1_q;
        end
    end

    assign bus.x            = x_q;
    assign bus.y            = y_q;
    assign bus.video_active = va_q;
    assign bus.line_start   = ls_q;
    assign bus.frame_start  = fs_q;
    assign bus.locked       = lk_q;
    assign bus.h_err        = he_q;
    assign bus.v_err        = ve_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a scaled 40x16 timing.
// Window: hpos 14..35, vpos 5..13; outputs lag the driven sample by 2.
module tb_vga_sync_decoder;

    localparam int HT = 40;
    localparam int HS = 8;
    localparam int VT = 16;

    typedef struct {
        int         cyc;
        logic [5:0] flg;
        bit         chk_xy;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   exp_lk = 1'b0;
    exp_t exp_q[$];

    vga_sync_decoder_if vif();

    vga_sync_decoder #(
        .H_SYNC(8), .H_BP(6), .H_TOTAL(40), .H_FP(4),
        .V_SYNC(2), .V_BP(3), .V_TOTAL(16), .V_FP(2),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Flags packed as {line_start, frame_start, locked, h_err, v_err, va}.
    always @(negedge clk) begin : mon
        logic [5:0] act;
        exp_t       e;
        act = {vif.line_start, vif.frame_start, vif.locked,
               vif.h_err, vif.v_err, vif.video_active};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_chk++;
            if (e.cyc != cyc || act !== e.flg ||
                (e.chk_xy && (vif.x !== e.x || vif.y !== e.y))) begin
                n_fail++;
                $display("FAIL out@%0d tag %0d: flags=%b x=%0d y=%0d, required flags=%b x=%0d y=%0d",
                         cyc, e.cyc, act, vif.x, vif.y, e.flg, e.x, e.y);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit ls, input bit fs,
                        input bit he, input bit ve,
                        input int h, input int v);
        exp_t e;
        bit   va;
        va = exp_lk && h >= 14 && h < 36 && v >= 5 && v < 14;
        e.cyc    = cyc + 2;
        e.flg    = {ls, fs, exp_lk, he, ve, va};
        e.chk_xy = va;
        e.x      = 10'(h - 14);
        e.y      = 10'(v - 5);
        exp_q.push_back(e);
    endtask

    task automatic line(input int v, input int len, input int hw,
                        input int lk_edge, input bit fs,
                        input bit he_edge, input bit ve,
                        input bit he_fall);
        for (int h = 0; h < len; h++) begin
            vif.hsync = (h < hw);
            vif.vsync = (v < 2);
            if (h == 0 && lk_edge >= 0) exp_lk = (lk_edge != 0);
            if (h == hw && he_fall) exp_lk = 1'b0;
            push(h == 0, fs && h == 0,
                 (h == 0 && he_edge) || (h == hw && he_fall),
                 ve && h == 0, h, v);
            step();
        end
    endtask

    // kind 1: line 'bad' one cycle short; kind 2: hsync one cycle narrow.
    task automatic frame(input int nl, input bit fs, input int lk,
                         input bit ve, input int bad, input int kind);
        int  len, hw, lkv;
        bit  he_edge, he_fall;
        for (int v = 0; v < nl; v++) begin
            len     = (v == bad && kind == 1) ? HT - 1 : HT;
            hw      = (v == bad && kind == 2) ? HS - 1 : HS;
            he_edge = (bad >= 0 && kind == 1 && v == bad + 1);
            he_fall = (v == bad && kind == 2);
            lkv     = (v == 0) ? lk : (he_edge ? 0 : -1);
            line(v, len, hw, lkv, fs && v == 0, he_edge,
                 ve && v == 0, he_fall);
        end
    endtask

    task automatic gap(input int n, input int to_idx);
        for (int g = 0; g < n; g++) begin
            vif.hsync = 1'b0;
            vif.vsync = 1'b0;
            if (g == to_idx) exp_lk = 1'b0;
            push(1'b0, 1'b0, g == to_idx, 1'b0, 1000, 0);
            step();
        end
    endtask

    task automatic rst_pulse(input int n);
        exp_t e;
        exp_lk = 1'b0;
        for (int i = 0; i < n; i++) begin
            rst       = 1'b1;
            vif.hsync = 1'b0;
            vif.vsync = 1'b0;
            if (exp_q.size() > 0 && exp_q[$].cyc == cyc + 1)
                void'(exp_q.pop_back());
            e.cyc    = cyc + 1;
            e.flg    = 6'b0;
            e.chk_xy = 1'b1;
            e.x      = 10'd0;
            e.y      = 10'd0;
            exp_q.push_back(e);
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        vif.hsync = 1'b0;
        vif.vsync = 1'b0;
        step();
        rst_pulse(3);
        gap(5, -1);

        // First frame edge is hidden by the reset-high line vsync history.
        frame(VT, 1'b0, -1, 1'b0, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1,  1, 1'b0, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);

        frame(VT, 1'b1, -1, 1'b0, 7, 1);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1,  1, 1'b0, -1, 0);

        frame(VT, 1'b1, -1, 1'b0, 7, 2);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1,  1, 1'b0, -1, 0);

        // hpos hits 1023 at gap index 1023 - HT after the line 6 edge.
        frame(7, 1'b1, -1, 1'b0, -1, 0);
        gap(1100, 1023 - HT);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1,  1, 1'b0, -1, 0);

        frame(6, 1'b1, -1, 1'b0, -1, 0);
        rst_pulse(1);
        gap(2, -1);
        for (int v = 6; v < VT; v++)
            line(v, HT, HS, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1,  1, 1'b0, -1, 0);

        frame(VT - 1, 1'b1, -1, 1'b0, -1, 0);
        frame(VT, 1'b1, 0, 1'b1, -1, 0);
        frame(VT, 1'b1, -1, 1'b0, -1, 0);
        gap(4, -1);
        repeat (4) step();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
